// File: rtl/somatorio_param.sv
// somatorio_param: sums a run of n operands accepted through a valid/ready
// handshake, with a sticky overflow flag (wrap or saturate) and a done pulse.
module somatorio_param #(
  parameter int unsigned W      = 8,
  parameter int unsigned CW     = 4,
  parameter int unsigned SATURA = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] n,
  input  logic [W-1:0]  valor,
  input  logic          valor_valid,
  output logic          valor_ready,
  output logic [W-1:0]  somatorio,
  output logic          ovf,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  acc, acc_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          ovf_nxt;
  logic [W:0]    sum;
  logic          beat;

  // Handshake and status are pure decodes of the state register
  assign valor_ready = (state == ACCUM);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign somatorio   = acc;
  assign beat        = valor_valid & valor_ready;
  assign sum         = {1'b0, acc} + {1'b0, valor};

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  // Next-state and accumulate logic
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    case (state)
      IDLE: begin
        if (start) begin
          acc_nxt = '0;
          ovf_nxt = 1'b0;
          if (n != '0) begin
            cnt_nxt   = n;
            state_nxt = ACCUM;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      ACCUM: begin
        if (beat) begin
          cnt_nxt = cnt - CW'(1);
          if (sum[W]) begin
            ovf_nxt = 1'b1;
            acc_nxt = (SATURA != 0) ? {W{1'b1}} : sum[W-1:0];
          end else begin
            acc_nxt = sum[W-1:0];
          end
          if (cnt == CW'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_somatorio_param.sv
// Bench for somatorio_param: wrap and saturate instances share stimulus and
// are compared every cycle against an arithmetic run model.
module tb_somatorio_param;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] n;
  logic [7:0] valor;
  logic       valor_valid;

  logic       ready_w, ovf_w, busy_w, done_w;
  logic [7:0] som_w;
  logic       ready_s, ovf_s, busy_s, done_s;
  logic [7:0] som_s;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  somatorio_param #(.W(8), .CW(4), .SATURA(0)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .n(n), .valor(valor),
    .valor_valid(valor_valid), .valor_ready(ready_w), .somatorio(som_w),
    .ovf(ovf_w), .busy(busy_w), .done(done_w)
  );

  somatorio_param #(.W(8), .CW(4), .SATURA(1)) u_sat (
    .clk(clk), .rst(rst), .start(start), .n(n), .valor(valor),
    .valor_valid(valor_valid), .valor_ready(ready_s), .somatorio(som_s),
    .ovf(ovf_s), .busy(busy_s), .done(done_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Run model: phase 0 idle, 1 collecting operands, 2 done pulse.
  // The sum is kept as an unbounded integer; outputs derive from it.
  int m_phase;
  int m_left;
  int m_total;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_left  <= 0;
      m_total <= 0;
    end else begin
      case (m_phase)
        0: if (start) begin
             m_total <= 0;
             if (n != 4'd0) begin
               m_left  <= int'(n);
               m_phase <= 1;
             end else begin
               m_phase <= 2;
             end
           end
        1: if (valor_valid) begin
             m_total <= m_total + int'(valor);
             m_left  <= m_left - 1;
             if (m_left == 1) m_phase <= 2;
           end
        default: m_phase <= 0;
      endcase
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready_w", 32'(ready_w), 32'(m_phase == 1));
      check("busy_w",  32'(busy_w),  32'(m_phase != 0));
      check("done_w",  32'(done_w),  32'(m_phase == 2));
      check("som_w",   32'(som_w),   32'(m_total % 256));
      check("ovf_w",   32'(ovf_w),   32'(m_total > 255));
      check("ready_s", 32'(ready_s), 32'(m_phase == 1));
      check("busy_s",  32'(busy_s),  32'(m_phase != 0));
      check("done_s",  32'(done_s),  32'(m_phase == 2));
      check("som_s",   32'(som_s),   32'((m_total > 255) ? 255 : m_total));
      check("ovf_s",   32'(ovf_s),   32'(m_total > 255));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] nn);
    start = 1'b1;
    n     = nn;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] v, input logic vld);
    valor       = v;
    valor_valid = vld;
    step();
    valor_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; n = '0; valor = '0; valor_valid = 1'b0;
    step();
    step();
    chk_en = 1'b1;
    rst = 1'b0;
    step();
    check("idle_busy", 32'(busy_w), 32'd0);

    // Reset asserted mid-run between edges clears outputs at once
    do_start(4'd3);
    feed(8'd10, 1'b1);
    check("pre_rst_som", 32'(som_w), 32'd10);
    rst = 1'b1;
    #2;
    check("rst_som",   32'(som_w),   32'd0);
    check("rst_busy",  32'(busy_w),  32'd0);
    check("rst_ready", 32'(ready_w), 32'd0);
    check("rst_done",  32'(done_w),  32'd0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_ready", 32'(ready_w), 32'd0);
    check("post_rst_busy",  32'(busy_w),  32'd0);

    // Simple run 10+20+30
    do_start(4'd3);
    feed(8'd10, 1'b1);
    feed(8'd20, 1'b1);
    feed(8'd30, 1'b1);
    check("run60_done", 32'(done_w), 32'd1);
    check("run60_som",  32'(som_w),  32'd60);
    check("run60_ovf",  32'(ovf_w),  32'd0);
    step();
    check("run60_hold", 32'(som_w), 32'd60);

    // Overflow: wrap gives 44, saturate gives 255
    do_start(4'd2);
    feed(8'd200, 1'b1);
    feed(8'd100, 1'b1);
    check("ovf_som_w", 32'(som_w), 32'd44);
    check("ovf_w_lit", 32'(ovf_w), 32'd1);
    check("ovf_som_s", 32'(som_s), 32'd255);
    check("ovf_s_lit", 32'(ovf_s), 32'd1);
    step();
    check("ovf_sticky", 32'(ovf_w), 32'd1);

    // Empty run clears ovf and pulses done next cycle
    do_start(4'd0);
    check("empty_done", 32'(done_w), 32'd1);
    check("empty_som",  32'(som_s),  32'd0);
    check("empty_ovf",  32'(ovf_s),  32'd0);
    step();

    // Stalled run: valid pattern 1,0,0,1,1,0,1
    do_start(4'd4);
    feed(8'd1, 1'b1);
    feed(8'd99, 1'b0);
    feed(8'd98, 1'b0);
    feed(8'd2, 1'b1);
    feed(8'd3, 1'b1);
    feed(8'd97, 1'b0);
    feed(8'd4, 1'b1);
    check("stall_done", 32'(done_w), 32'd1);
    check("stall_som",  32'(som_w),  32'd10);
    feed(8'd50, 1'b1);
    feed(8'd50, 1'b1);
    check("stall_noextra", 32'(som_w), 32'd10);

    // start during ACCUM and DONE is ignored
    do_start(4'd2);
    feed(8'd5, 1'b1);
    start = 1'b1;
    n     = 4'd7;
    feed(8'd6, 1'b1);
    check("ign_done", 32'(done_w), 32'd1);
    check("ign_som",  32'(som_w),  32'd11);
    n = 4'd0;
    step();
    start = 1'b0;
    check("ign_idle", 32'(busy_w), 32'd0);
    check("ign_hold", 32'(som_w),  32'd11);

    // Back-to-back: B starts on first IDLE cycle after A's done
    do_start(4'd1);
    feed(8'd7, 1'b1);
    check("a_done", 32'(done_w), 32'd1);
    check("a_som",  32'(som_w),  32'd7);
    step();
    check("a_held", 32'(som_w), 32'd7);
    do_start(4'd2);
    check("b_cleared", 32'(som_w), 32'd0);
    feed(8'd5, 1'b1);
    feed(8'd5, 1'b1);
    check("b_done", 32'(done_w), 32'd1);
    check("b_som",  32'(som_w),  32'd10);
    check("b_ovf",  32'(ovf_w),  32'd0);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
